// File: rtl/rr_ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among three cores.
// Optional per-core grant counters enabled by defining ARB_STATS_EN.
module rr_ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic [2:0]      rden,
    input  logic [2:0]      wren,
    input  logic [3*AW-1:0] Address,
    input  logic [3*DW-1:0] Din,
    input  logic [DW-1:0]   RAMq,
    output logic [2:0]      acq,
    output logic [3*DW-1:0] Dq,
    output logic [AW-1:0]   RAMAddress,
    output logic [DW-1:0]   RAMDin,
`ifdef ARB_STATS_EN
    output logic [47:0]     grant_count,
`endif
    output logic            RAMwren
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t     state;
    logic [1:0] last;
    logic [1:0] win;
    logic       is_wr;
    logic [2:0] req;
    logic [1:0] pick;

    assign req = rden | wren;

    // search starts one past the previous winner and wraps
    always_comb begin
        pick = 2'd0;
        case (last)
            2'd0: begin
                if (req[1])      pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else             pick = 2'd0;
            end
            2'd1: begin
                if (req[2])      pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else             pick = 2'd1;
            end
            default: begin
                if (req[0])      pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else             pick = 2'd2;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 2'd2;
            win        <= 2'd0;
            is_wr      <= 1'b0;
            acq        <= '0;
            Dq         <= '0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            RAMwren    <= 1'b0;
`ifdef ARB_STATS_EN
            grant_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        win        <= pick;
                        last       <= pick;
                        is_wr      <= wren[pick];
                        RAMAddress <= Address[pick*AW +: AW];
                        RAMDin     <= Din[pick*DW +: DW];
                        RAMwren    <= wren[pick];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    RAMwren <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (!is_wr) begin
                        Dq[win*DW +: DW] <= RAMq;
                    end
                    acq   <= 3'b001 << win;
                    state <= ACK;
`ifdef ARB_STATS_EN
                    grant_count[win*16 +: 16] <=
                        grant_count[win*16 +: 16] + 16'd1;
`endif
                end
                ACK: begin
                    acq   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_ram_arbiter.sv
// Self-checking bench for rr_ram_arbiter: vector table, scoreboard,
// contention and mid-access reset sequences.
module tb_rr_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic [2:0]      rden;
    logic [2:0]      wren;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] din;
    logic [DW-1:0]   ram_q;
    logic [2:0]      acq;
    logic [3*DW-1:0] dq;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic            ram_wren;
`ifdef ARB_STATS_EN
    logic [47:0]     grant_count;
`endif

    rr_ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK        (clk),
        .rst_n      (rst_n),
        .rden       (rden),
        .wren       (wren),
        .Address    (addr),
        .Din        (din),
        .RAMq       (ram_q),
        .acq        (acq),
        .Dq         (dq),
        .RAMAddress (ram_addr),
        .RAMDin     (ram_din),
`ifdef ARB_STATS_EN
        .grant_count(grant_count),
`endif
        .RAMwren    (ram_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port synchronous RAM, one-cycle read latency
    logic [DW-1:0] mem [0:255];
    logic          load;
    always @(posedge clk) begin
        if (load) begin
            mem[8'h10] <= 8'hA5;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_din;
        end
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        int         core;
        logic       rd;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_dq;
    } vec_t;

    typedef struct {
        int         core;
        logic       wr;
        logic [7:0] data;
    } exp_t;

    exp_t            sb[$];
    logic [3*DW-1:0] dq_model;
    logic [2:0]      prev_acq;
    int              n_vec;
    int              n_err;
    vec_t            tbl[8];

    function automatic void chk(string name,
                                logic [63:0] act,
                                logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (acq != 3'b000) begin
                chk("acq_single_cycle", {61'd0, prev_acq}, 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_acq", {61'd0, acq}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_acq", {61'd0, acq},
                        {61'd0, 3'b001 << e.core});
                    if (!e.wr) dq_model[e.core*DW +: DW] = e.data;
                    chk("sb_dq", {40'd0, dq}, {40'd0, dq_model});
                end
            end
            prev_acq = acq;
        end else begin
            prev_acq = 3'b000;
        end
    end

    task automatic drop_all();
        rden = '0;
        wren = '0;
    endtask

    task automatic run_vec(vec_t v);
        @(negedge clk);
        rden[v.core] = v.rd;
        wren[v.core] = v.wr;
        addr[v.core*AW +: AW] = v.a;
        din[v.core*DW +: DW]  = v.d;
        sb.push_back('{v.core, v.wr, v.exp_dq});
        @(negedge clk);
        chk("ram_addr_t1", {56'd0, ram_addr}, {56'd0, v.a});
        chk("ram_wren_t1", {63'd0, ram_wren}, {63'd0, v.wr});
        if (v.wr) chk("ram_din_t1", {56'd0, ram_din}, {56'd0, v.d});
        @(negedge clk);
        chk("ram_wren_t2", {63'd0, ram_wren}, 64'd0);
        chk("acq_t2", {61'd0, acq}, 64'd0);
        @(negedge clk);
        chk("acq_t3", {61'd0, acq}, {61'd0, 3'b001 << v.core});
        drop_all();
        @(negedge clk);
        chk("acq_t4", {61'd0, acq}, 64'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        dq_model = '0;
        prev_acq = '0;
        rst_n    = 1'b0;
        load     = 1'b1;
        rden     = '0;
        wren     = '0;
        addr     = '0;
        din      = '0;

        tbl[0] = '{1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[1] = '{2, 1'b0, 1'b1, 8'h20, 8'h3C, 8'h00};
        tbl[2] = '{0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
        tbl[3] = '{0, 1'b1, 1'b1, 8'h30, 8'h77, 8'h00};
        tbl[4] = '{1, 1'b1, 1'b0, 8'h30, 8'h00, 8'h77};
        tbl[5] = '{2, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[6] = '{0, 1'b0, 1'b1, 8'hFF, 8'h01, 8'h00};
        tbl[7] = '{2, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h01};

        repeat (3) @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs",
                {21'd0, acq, dq, ram_addr, ram_din, ram_wren},
                64'd0);
        end

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // reset during the ISSUE cycle of a write
        @(negedge clk);
        wren[0] = 1'b1;
        addr[0 +: AW] = 8'h40;
        din[0 +: DW]  = 8'h99;
        @(negedge clk);
        chk("abort_wren_pre", {63'd0, ram_wren}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wren", {63'd0, ram_wren}, 64'd0);
        chk("abort_acq", {61'd0, acq}, 64'd0);
        chk("abort_outs", {32'd0, dq, ram_addr}, 64'd0);
        dq_model = '0;
        sb.delete();
        drop_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // three-way contention; order 0,1,2 proves last reset to 2
        @(negedge clk);
        addr = {8'h30, 8'h20, 8'h10};
        rden = 3'b111;
        sb.push_back('{0, 1'b0, 8'hA5});
        sb.push_back('{1, 1'b0, 8'h3C});
        sb.push_back('{2, 1'b0, 8'h77});
        for (int c = 1; c <= 12; c++) begin
            logic [2:0] ea;
            @(negedge clk);
            ea = (c == 3)  ? 3'b001 :
                 (c == 7)  ? 3'b010 :
                 (c == 11) ? 3'b100 : 3'b000;
            chk("contention_acq", {61'd0, acq}, {61'd0, ea});
            rden = rden & ~acq;
        end
        chk("contention_dq", {40'd0, dq},
            {40'd0, 8'h77, 8'h3C, 8'hA5});

`ifdef ARB_STATS_EN
        chk("grant_count", {16'd0, grant_count},
            {16'd0, 16'd1, 16'd1, 16'd1});
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
